// File: rtl/ram_dp_be.sv
// ram_dp_be: simple dual-port synchronous RAM with per-byte write enables.
//   One write port (we/waddr/wdata/wbe) and one independent read port
//   (re/raddr -> rdata/rvalid, latency 1, write-first on address collision).
//   A clear sequencer zeroes every entry after reset and on a clear pulse;
//   busy is high while it runs and the ports are ignored.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 single-cycle request to zero all entries
//   we, waddr, wdata, wbe write port; wbe[i] covers wdata[8i+7:8i]
//   re, raddr             read request
//   rdata, rvalid         registered read data and one-cycle valid strobe
//   busy                  clear sequence in progress
// Optional feature (macro RAM_PARITY_EN): one even-parity bit per byte lane,
//   input par_flip inverts the stored parity of written lanes, output perr
//   flags a parity mismatch alongside rvalid.
module ram_dp_be #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BE_WIDTH-1:0]   wbe,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
`ifdef RAM_PARITY_EN
  input  logic                  par_flip,
  output logic                  perr,
`endif
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  wr_fire, rd_fire, clr_fire;
  logic                  hit;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef RAM_PARITY_EN
  logic [BE_WIDTH-1:0]   mem_par [DEPTH];
  logic                  rd_perr;
`endif

  // Next state, clear address and port qualification; clear beats we/re
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_fire   = 1'b0;
    wr_fire    = 1'b0;
    rd_fire    = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_fire   = 1'b1;
        clr_addr_d = ADDR_WIDTH'(clr_addr_q + 1'b1);
        if (clr_addr_q == LAST_ADDR) state_d = IDLE;
      end
      IDLE: begin
        if (clear) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end else begin
          wr_fire = we;
          rd_fire = re;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Write-first merge: lanes being written this cycle bypass the array
  always_comb begin
    hit     = wr_fire && (waddr == raddr);
    rd_word = mem[raddr];
`ifdef RAM_PARITY_EN
    rd_perr = 1'b0;
`endif
    for (int i = 0; i < int'(BE_WIDTH); i++) begin
      if (hit && wbe[i]) begin
        rd_word[8*i +: 8] = wdata[8*i +: 8];
      end
`ifdef RAM_PARITY_EN
      else if ((^mem[raddr][8*i +: 8]) != mem_par[raddr][i]) begin
        rd_perr = 1'b1;
      end
`endif
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      busy       <= 1'b1;
      rvalid     <= 1'b0;
      rdata      <= '0;
`ifdef RAM_PARITY_EN
      perr       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy       <= (state_d == CLEAR);
      rvalid     <= rd_fire;
      if (rd_fire) rdata <= rd_word;
`ifdef RAM_PARITY_EN
      perr       <= rd_fire && rd_perr;
`endif
    end
  end

  // Storage array; no reset, zeroed by the clear sequencer instead
  always_ff @(posedge clk) begin
    if (clr_fire) begin
      mem[clr_addr_q] <= '0;
`ifdef RAM_PARITY_EN
      mem_par[clr_addr_q] <= '0;
`endif
    end else if (wr_fire) begin
      for (int i = 0; i < int'(BE_WIDTH); i++) begin
        if (wbe[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
`ifdef RAM_PARITY_EN
          mem_par[waddr][i] <= (^wdata[8*i +: 8]) ^ par_flip;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: directed self-checking bench for ram_dp_be (16-bit, 16 entries).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_ram_dp_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic [1:0]  wbe;
  logic        re;
  logic [3:0]  raddr;
  logic [15:0] rdata;
  logic        rvalid;
  logic        busy;
`ifdef RAM_PARITY_EN
  logic        par_flip;
  logic        perr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ram_dp_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .wbe    (wbe),
    .re     (re),
    .raddr  (raddr),
`ifdef RAM_PARITY_EN
    .par_flip (par_flip),
    .perr     (perr),
`endif
    .rdata  (rdata),
    .rvalid (rvalid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    clear = 1'b0; we = 1'b0; re = 1'b0;
    waddr = '0; wdata = '0; wbe = '0; raddr = '0;
`ifdef RAM_PARITY_EN
    par_flip = 1'b0;
`endif
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    idle_in();
    we = 1'b1; waddr = a; wdata = d; wbe = be;
    cyc();
    we = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
    idle_in();
    re = 1'b1; raddr = a;
    cyc();
    re = 1'b0;
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, 32'(rdata), 32'(exp));
  endtask

  // 16 edges of busy, low only after the last one
  task automatic busy_window(input string tag);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      check(tag, 32'(busy), (k < 16) ? 32'd1 : 32'd0);
      check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    end
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    re = 1'b1; raddr = 4'd3;
    #23;
    check("rst_busy",   32'(busy),   32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata",  32'(rdata),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Power-up clear with re held: reads ignored until busy drops
    busy_window("pwr_busy");
    cyc();
    check("first_rvalid", 32'(rvalid), 32'd1);
    check("first_rdata",  32'(rdata),  32'h0000);

    // Byte-lane merge across two writes
    wr(4'd5, 16'hBEEF, 2'b11);
    wr(4'd5, 16'h1234, 2'b01);
    rd_check("lane_merge", 4'd5, 16'hBE34);
    idle_in();
    cyc();
    check("idle_rvalid", 32'(rvalid), 32'd0);
    check("idle_hold",   32'(rdata),  32'hBE34);

    // Same-address collision, write-first with partial byte enables
    wr(4'd7, 16'h1111, 2'b11);
    idle_in();
    we = 1'b1; waddr = 4'd7; wdata = 16'hA5A5; wbe = 2'b10;
    re = 1'b1; raddr = 4'd7;
    cyc();
    check("coll_rvalid", 32'(rvalid), 32'd1);
    check("coll_rdata",  32'(rdata),  32'hA511);

    // Independent addresses in the same cycle, and wbe=0 no-op
    idle_in();
    we = 1'b1; waddr = 4'd8; wdata = 16'h2222; wbe = 2'b11;
    re = 1'b1; raddr = 4'd7;
    cyc();
    check("indep_rdata", 32'(rdata), 32'hA511);
    wr(4'd8, 16'hFFFF, 2'b00);

    // Back-to-back reads keep rvalid high
    idle_in();
    re = 1'b1;
    raddr = 4'd5; cyc();
    check("b2b0_rvalid", 32'(rvalid), 32'd1);
    check("b2b0_rdata",  32'(rdata),  32'hBE34);
    raddr = 4'd7; cyc();
    check("b2b1_rvalid", 32'(rvalid), 32'd1);
    check("b2b1_rdata",  32'(rdata),  32'hA511);
    raddr = 4'd8; cyc();
    check("b2b2_rvalid", 32'(rvalid), 32'd1);
    check("b2b2_rdata",  32'(rdata),  32'h2222);

    // Fill, then clear with a colliding write and read that must be dropped
    for (int a = 0; a < 16; a++) wr(4'(a), 16'h0100 + 16'(a), 2'b11);
    rd_check("fill15", 4'd15, 16'h010F);
    idle_in();
    clear = 1'b1;
    we = 1'b1; waddr = 4'd3; wdata = 16'hDEAD; wbe = 2'b11;
    re = 1'b1; raddr = 4'd4;
    cyc();
    check("clr_start_busy",   32'(busy),   32'd1);
    check("clr_start_rvalid", 32'(rvalid), 32'd0);
    idle_in();
    busy_window("clr_busy");
    idle_in();
    re = 1'b1;
    for (int a = 0; a < 16; a++) begin
      raddr = 4'(a);
      cyc();
      check("cleared_rvalid", 32'(rvalid), 32'd1);
      check("cleared_rdata",  32'(rdata),  32'h0000);
    end

    // Reset during an in-flight read drops it
    wr(4'd15, 16'hFFFF, 2'b11);
    rd_check("pre_rst", 4'd15, 16'hFFFF);
    rst_n = 1'b0;
    #1;
    check("rst_read_rvalid", 32'(rvalid), 32'd0);
    check("rst_read_rdata",  32'(rdata),  32'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset again during the 8th clear edge; clear must restart and reach addr 15
    for (int k = 0; k < 7; k++) cyc();
    check("mid_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    busy_window("restart_busy");
    rd_check("restart_a15", 4'd15, 16'h0000);

`ifdef RAM_PARITY_EN
    idle_in();
    we = 1'b1; waddr = 4'd2; wdata = 16'h00FF; wbe = 2'b01; par_flip = 1'b1;
    cyc();
    rd_check("par_bad", 4'd2, 16'h00FF);
    check("perr_set", 32'(perr), 32'd1);
    wr(4'd2, 16'h00FF, 2'b01);
    rd_check("par_ok", 4'd2, 16'h00FF);
    check("perr_clr", 32'(perr), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
